// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Central reset generator. Collects power-on (async_reset_n), a debounced
//   external button (ext_rst_req) and a software pulse (sw_rst_req), stretches
//   every request to HOLD_CYCLES, then releases the active-high stage resets
//   one at a time (bit 0 first) with STAGE_GAP cycles between releases.
//
//   Optional feature macro: RST_WATCHDOG_EN
//     When defined, a watchdog counts cycles in RUN. It is cleared by wdt_kick
//     or by leaving RUN. Reaching WDT_CYCLES-1 raises a reset request with cause 11.
//     When undefined, wdt_kick is ignored and cause 11 never occurs.
//
// Ports
//   clk           in   system clock
//   async_reset_n in   asynchronous active-low power-on reset
//   ext_rst_req   in   raw asynchronous button, active high
//   sw_rst_req    in   synchronous single-cycle software reset pulse
//   wdt_kick      in   watchdog service pulse
//   rst_out       out  NUM_STAGES active-high stage resets, bit 0 released first
//   all_released  out  high only once every stage is released (RUN)
//   rst_cause     out  last reset cause: 00 POR, 01 ext, 10 sw, 11 watchdog
module reset_sequencer #(
  parameter int NUM_STAGES      = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int WDT_CYCLES      = 1024
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic                  ext_rst_req,
  input  logic                  sw_rst_req,
  input  logic                  wdt_kick,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  all_released,
  output logic [1:0]            rst_cause
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int GAP_W  = $clog2(STAGE_GAP) + 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int IDX_W  = $clog2(NUM_STAGES) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      idx_next;
  logic [NUM_STAGES-1:0] rst_d;
  logic [1:0]            cause_d;

  logic                  ext_s1, ext_s2;
  logic [DEB_W-1:0]      deb_cnt;
  logic                  ext_req;
  logic                  wdt_expire;
  logic                  req;

  // Button path: two-flop synchronizer, then a saturating run-length counter.
  // A single low synced sample restarts the count, so short glitches are lost.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      ext_s1  <= 1'b0;
      ext_s2  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      ext_s1 <= ext_rst_req;
      ext_s2 <= ext_s1;
      if (!ext_s2) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign ext_req = (deb_cnt == DEB_MAX);

`ifdef RST_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES) + 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      wdt_cnt <= '0;
    end else if ((state_q != ST_RUN) || wdt_kick) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  // Expiry lasts one cycle: the request it raises drops the FSM out of RUN,
  // which clears the counter on the following edge.
  assign wdt_expire = (state_q == ST_RUN) && (wdt_cnt == WDT_LAST);
`else
  logic unused_kick;
  assign unused_kick = wdt_kick;
  assign wdt_expire  = 1'b0;
`endif

  assign req = ext_req | sw_rst_req | wdt_expire;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q   <= ST_HOLD;
      hold_q    <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      rst_out   <= '1;
      rst_cause <= 2'b00;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      rst_out   <= rst_d;
      rst_cause <= cause_d;
    end
  end

  assign idx_next = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_d   = rst_out;
    cause_d = rst_cause;

    // A request overrides any release scheduled for the same edge.
    if (req) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      rst_d   = '1;
      if (ext_req) begin
        cause_d = 2'b01;
      end else if (wdt_expire) begin
        cause_d = 2'b11;
      end else begin
        cause_d = 2'b10;
      end
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            rst_d[0] = 1'b0;
            gap_d    = '0;
            idx_d    = '0;
            state_d  = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
              if (idx_next == IDX_W'(k)) begin
                rst_d[k] = 1'b0;
              end
            end
            idx_d = idx_next;
            gap_d = '0;
            if (idx_next == IDX_LAST) begin
              state_d = ST_RUN;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
          hold_d  = '0;
          rst_d   = '1;
        end
      endcase
    end
  end

  assign all_released = (state_q == ST_RUN);

endmodule
